shift_add_mac: RTL and testbench
================================

# shift_add_mac

Iterative shift-add multiply-accumulate unit computing p = a*b + c, one multiplier bit per clock. It is the inverse of the team's subtract-shift divider. Feeding it divisor (a), quotient (b) and remainder (c) reconstructs the dividend, so it serves both as a standalone small multiplier and as the checker stage behind the divider. Control uses a start/busy/done handshake matching the divider.

## Interface
- W, default 4: operand width. Result width is 2W.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- a  in  W  multiplicand (unsigned). Divisor when used as a checker.
- b  in  W  multiplier (unsigned). Quotient when used as a checker.
- c  in  W  addend (unsigned). Remainder when used as a checker.
- p  out  2W  registered result a*b + c. Holds until the next completion or reset.
- busy  out  1  high while an operation is in progress (RUN state).
- done  out  1  one-cycle completion pulse. p is valid when done=1.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 moves to RUN, else stay.
  - RUN: stays W cycles (step counter 0..W-1), then moves to DONE.
  - DONE: always returns to IDLE after one cycle.
- On start accepted (IDLE, start=1):
  - acc (2W bits) <= zero-extended c.
  - mcand (2W bits) <= zero-extended a.
  - mplier (W bits) <= b.
  - cnt <= 0.
- Each RUN cycle:
  - If mplier[0]=1, acc <= acc + mcand (2W-bit add).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
- Leaving RUN (cnt = W-1 step): p <= final acc, including the last step's add.
- Width rule: the maximum is (2^W-1)^2 + (2^W-1) = 2^W*(2^W-1) < 2^(2W), so there is never overflow and no carry-out is needed.
- No early termination. Every operation takes exactly W steps, including a=0 or b=0.
- a, b, c are captured only at acceptance. Later changes have no effect on the running operation.
- start is ignored in RUN and DONE: no queuing and no restart. A start held high through DONE is accepted on the following IDLE cycle.
- Reset values: state IDLE, p=0, busy=0, done=0, acc/mcand/mplier/cnt=0.
- rst has priority over start.
- rst mid-operation aborts immediately: no done pulse, p=0, next start behaves normally.

## Timing
- Let edge k be the edge that samples start=1 in IDLE.
- busy=1 from after edge k through edge k+W, i.e. W cycles.
- Edges k+1 .. k+W each perform one step.
- After edge k+W: state DONE, done=1, busy=0, p valid. Latency is W cycles from acceptance to done.
- After edge k+W+1: IDLE, done=0. p holds.
- Earliest next acceptance is edge k+W+2, giving a throughput of one result per W+2 cycles.
- busy and done are never high together.

## Test plan
- W=4, rst 2 cycles, then start with a=2, b=3, c=0 -> busy high 4 cycles, done pulse exactly 4 cycles after acceptance, p=6.
- Divider inverse, a=2 (divisor), b=3 (quotient), c=1 (remainder) -> p=7. Sweep all a in 1..15 and D in 0..15 with b=D/a, c=D%a -> p=D every time.
- Max operands a=15, b=15, c=15 -> p=240 (0xF0), no overflow. Also a=0, b=9, c=5 -> p=5 with full 4-cycle latency.
- start a=3, b=5, c=2. Two cycles later drive a=9, b=1, c=0 and pulse start -> p=17, exactly one done pulse, second start not accepted.
- start a=7, b=7, c=0. Assert rst for 1 cycle two cycles later -> busy=0, done never pulses, p=0. Then start a=4, b=4, c=3 -> p=19 after 4 cycles.
- Hold start=1 continuously with a=1, b=1, c=1 -> done pulses every 6 cycles, p=2 each time, busy low exactly during DONE and IDLE cycles.

Source files
------------

// File: rtl/shift_add_mac.sv
// shift_add_mac: iterative shift-add multiply-accumulate, p = a*b + c, one multiplier bit per clock
module shift_add_mac #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DN   = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [1:0]    state;
    logic [2*W-1:0] acc, mcand, acc_n;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;

    // Accumulator after this step's conditional add; also the value latched into p on the last step
    always_comb acc_n = mplier[0] ? acc + mcand : acc;

    // Control and datapath: load on acceptance, one shift-add per RUN cycle, one-cycle DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            p      <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                acc    <= {{W{1'b0}}, c};
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                cnt    <= '0;
                state  <= RUN;
            end
        end else if (state == RUN) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                p     <= acc_n;
                state <= DN;
            end
        end else begin
            state <= IDLE;
        end
    end

    // Status decodes straight from the state register, so busy and done are mutually exclusive
    always_comb begin
        busy = (state == RUN);
        done = (state == DN);
    end
endmodule

// File: tb/tb_shift_add_mac.sv
// tb_shift_add_mac: table, sweep, random and corner-sequence checks of shift_add_mac against a*b+c
module tb_shift_add_mac;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [3:0] a = 0, b = 0, c = 0;
    logic [7:0] p;
    logic       busy, done;
    int pass_cnt = 0;
    int total = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int p;
    } vec_t;

    vec_t tv[6];

    shift_add_mac #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .p(p), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // One full operation: accept, then expect W=4 busy cycles, done after exactly 4, p = exp
    task automatic op(input int ta, input int tb_, input int tc, input int exp, input string nm);
        int lat, busyc, both;
        @(negedge clk);
        a = 4'(ta); b = 4'(tb_); c = 4'(tc); start = 1;
        @(negedge clk);
        start = 0;
        lat = 0; busyc = 0; both = 0;
        while (!done && lat < 20) begin
            if (busy) busyc++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) both = 1;
        chk({nm, " latency"}, lat, 4);
        chk({nm, " p"}, int'(p), exp);
        chk({nm, " busy cycles"}, busyc, 4);
        chk({nm, " busy&done"}, both, 0);
    endtask

    initial begin
        int dcount, pval, ra, rb, rc;
        tv[0] = '{a: 2,  b: 3,  c: 0,  p: 6};
        tv[1] = '{a: 2,  b: 3,  c: 1,  p: 7};
        tv[2] = '{a: 15, b: 15, c: 15, p: 240};
        tv[3] = '{a: 0,  b: 9,  c: 5,  p: 5};
        tv[4] = '{a: 1,  b: 1,  c: 1,  p: 2};
        tv[5] = '{a: 4,  b: 0,  c: 11, p: 11};

        repeat (2) @(negedge clk);
        rst = 0;
        chk("reset p", int'(p), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);

        foreach (tv[i]) op(tv[i].a, tv[i].b, tv[i].c, tv[i].p, $sformatf("vec%0d", i));

        // Divider inverse: divisor*quotient + remainder rebuilds the dividend
        for (int da = 1; da < 16; da++)
            for (int dd = 0; dd < 16; dd++)
                op(da, dd / da, dd % da, dd, $sformatf("inv a=%0d D=%0d", da, dd));

        for (int i = 0; i < 60; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 15));
            op(ra, rb, rc, ra * rb + rc, $sformatf("rand %0d*%0d+%0d", ra, rb, rc));
        end

        // Operands change and start re-pulses mid-run: first operation must finish untouched, once
        @(negedge clk);
        a = 3; b = 5; c = 2; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        a = 9; b = 1; c = 0; start = 1;
        @(negedge clk);
        start = 0;
        dcount = 0; pval = -1;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dcount++;
                pval = int'(p);
            end
            @(negedge clk);
        end
        chk("midrun done count", dcount, 1);
        chk("midrun p", pval, 17);
        chk("midrun no restart busy", int'(busy), 0);

        // Reset two cycles into a run aborts it with no done pulse and p cleared
        @(negedge clk);
        a = 7; b = 7; c = 0; start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort busy", int'(busy), 0);
        chk("abort p", int'(p), 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("abort no done", dcount, 0);
        op(4, 4, 3, 19, "after abort");

        // start held high: one result every W+2 = 6 cycles
        @(negedge clk);
        a = 1; b = 1; c = 1; start = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("hold busy %0d", i), int'(busy), (i % 6) < 4 ? 1 : 0);
            chk($sformatf("hold done %0d", i), int'(done), (i % 6) == 4 ? 1 : 0);
            if (i % 6 == 4) chk($sformatf("hold p %0d", i), int'(p), 2);
        end
        start = 0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
